// File: rtl/seq_divider_8_bit.sv
// Multi-cycle unsigned restoring divider (dividend / divisor -> quotient,
// remainder). Each iteration borrows the external 8-bit add/sub stage:
// operands are driven out combinationally, and sum/borrow come back in the
// same cycle.
module seq_divider_8_bit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_sel,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_c_out
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  state_t         next_state;
  logic [CW-1:0]  count;
  logic [WIDTH-1:0] r_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] d_reg;

  logic [WIDTH:0]   shifted;
  logic             ok;
  logic [WIDTH-1:0] r_next;
  logic [WIDTH-1:0] q_next;
  logic             last_iter;
  logic             zero_div;

  assign last_iter = (count == CW'(WIDTH - 1));
  assign zero_div  = (divisor == '0);

  // Next-state logic for the IDLE -> CALC/DONE -> IDLE sequence.
  always_comb begin
    // NOTE: every signal assigned in always_comb gets a default first;
    // a path that skips an assignment would otherwise infer a latch.
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = zero_div ? DONE : CALC;
      CALC:    if (last_iter) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // One restoring step: shift in the next dividend bit, trial-subtract the
  // divisor on the external stage, keep the difference when it did not borrow.
  // A set carry-out bit of the shifted value means it already exceeds any
  // 8-bit divisor, and the stage's mod-256 difference is then still exact.
  always_comb begin
    shifted = {r_reg, q_reg[WIDTH-1]};
    ok      = shifted[WIDTH] | ~add_c_out;
    r_next  = ok ? add_sum : shifted[WIDTH-1:0];
    q_next  = {q_reg[WIDTH-2:0], ok};
    add_a   = '0;
    add_b   = '0;
    add_sel = 1'b0;
    if (state == CALC) begin
      add_a   = shifted[WIDTH-1:0];
      add_b   = d_reg;
      add_sel = 1'b1;
    end
  end

  // State register plus registered handshake flags derived from next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values, independent of statement order.
      state <= next_state;
      busy  <= (next_state != IDLE);
      done  <= (next_state == DONE);
    end
  end

  // Operand capture, iteration datapath and result registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count       <= '0;
      r_reg       <= '0;
      q_reg       <= '0;
      d_reg       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (zero_div) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              r_reg       <= '0;
              q_reg       <= dividend;
              d_reg       <= divisor;
              count       <= '0;
              div_by_zero <= 1'b0;
            end
          end
        end
        CALC: begin
          r_reg <= r_next;
          q_reg <= q_next;
          count <= count + 1'b1;
          if (last_iter) begin
            quotient  <= q_next;
            remainder <= r_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider_8_bit.sv
// Self-checking bench for seq_divider_8_bit: directed boundary cases, abort
// by reset, ignored start while busy, and randomized operands compared with
// plain integer division.
module tb_seq_divider_8_bit;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;
  logic [7:0] add_a;
  logic [7:0] add_b;
  logic       add_sel;
  logic [7:0] add_sum;
  logic       add_c_out;

  int checks   = 0;
  int failures = 0;

  logic [7:0] prev_q = 8'h00;
  logic [7:0] prev_r = 8'h00;

  always #5 clk = ~clk;

  seq_divider_8_bit dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_sel    (add_sel),
    .add_sum    (add_sum),
    .add_c_out  (add_c_out)
  );

  // Shared add/sub stage: sel=1 subtracts, c_out is the borrow (a<b).
  logic [8:0] stage_sum;
  logic [8:0] stage_diff;
  assign stage_sum  = {1'b0, add_a} + {1'b0, add_b};
  assign stage_diff = {1'b0, add_a} - {1'b0, add_b};
  assign add_sum    = add_sel ? stage_diff[7:0] : stage_sum[7:0];
  assign add_c_out  = add_sel ? stage_diff[8]   : stage_sum[8];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Issue one operation from IDLE (called at a falling edge) and follow it to
  // completion. If intr_k is nonzero, a second start carrying ia/ib is pulsed
  // on the intr_k-th rising edge after acceptance and must be ignored.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input int intr_k, input logic [7:0] ia, input logic [7:0] ib);
    logic [7:0] exp_q;
    logic [7:0] exp_r;
    logic       exp_z;
    int         exp_lat;
    int         k;
    logic       busy_ok;
    logic       sel_ok;
    logic       held_ok;

    exp_z   = (b == 8'd0);
    exp_q   = exp_z ? 8'hFF : 8'(a / b);
    exp_r   = exp_z ? a : 8'(a % b);
    exp_lat = exp_z ? 1 : 9;

    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(negedge clk);
    start    = 1'b0;
    dividend = 8'($urandom);
    divisor  = 8'($urandom);

    busy_ok = 1'b1;
    sel_ok  = 1'b1;
    held_ok = 1'b1;
    k = 1;
    while (!done && k < 20) begin
      if (!busy) busy_ok = 1'b0;
      if (add_sel !== 1'b1) sel_ok = 1'b0;
      if (quotient !== prev_q || remainder !== prev_r) held_ok = 1'b0;
      if (k == intr_k) begin
        start    = 1'b1;
        dividend = ia;
        divisor  = ib;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    start = 1'b0;

    check("latency", 32'(k), 32'(exp_lat));
    check("quotient", {24'd0, quotient}, {24'd0, exp_q});
    check("remainder", {24'd0, remainder}, {24'd0, exp_r});
    check("div_by_zero", {31'd0, div_by_zero}, {31'd0, exp_z});
    check("busy_in_done", {31'd0, busy}, 32'd1);
    check("sel_in_done", {31'd0, add_sel}, 32'd0);
    if (!exp_z) begin
      check("busy_in_calc", {31'd0, busy_ok}, 32'd1);
      check("sel_in_calc", {31'd0, sel_ok}, 32'd1);
      check("results_held", {31'd0, held_ok}, 32'd1);
    end

    @(negedge clk);
    check("done_one_cycle", {31'd0, done}, 32'd0);
    check("busy_idle", {31'd0, busy}, 32'd0);
    check("sel_idle", {31'd0, add_sel}, 32'd0);
    prev_q = exp_q;
    prev_r = exp_r;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic       saw_done;
    logic [7:0] ra;
    logic [7:0] rb;

    reset_n  = 1'b0;
    start    = 1'b0;
    dividend = 8'd0;
    divisor  = 8'd0;
    @(negedge clk);
    @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_quotient", {24'd0, quotient}, 32'd0);
    check("rst_remainder", {24'd0, remainder}, 32'd0);
    check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    check("rst_add_a", {24'd0, add_a}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Directed cases.
    run_op(8'd100, 8'd7, 0, 8'd0, 8'd0);
    run_op(8'd255, 8'd1, 0, 8'd0, 8'd0);
    run_op(8'd200, 8'd201, 0, 8'd0, 8'd0);
    run_op(8'd255, 8'd128, 0, 8'd0, 8'd0);
    run_op(8'd255, 8'd255, 0, 8'd0, 8'd0);
    run_op(8'd37, 8'd0, 0, 8'd0, 8'd0);
    run_op(8'd37, 8'd5, 0, 8'd0, 8'd0);

    // Start while busy is ignored, then accepted from IDLE.
    run_op(8'd100, 8'd7, 4, 8'd9, 8'd3);
    run_op(8'd9, 8'd3, 0, 8'd0, 8'd0);

    // Abort by asynchronous reset in the middle of the cycle after E3.
    start    = 1'b1;
    dividend = 8'd100;
    divisor  = 8'd7;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_quotient", {24'd0, quotient}, 32'd0);
    check("abort_remainder", {24'd0, remainder}, 32'd0);
    check("abort_dbz", {31'd0, div_by_zero}, 32'd0);
    check("abort_sel", {31'd0, add_sel}, 32'd0);
    check("abort_add_a", {24'd0, add_a}, 32'd0);
    saw_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    check("abort_no_done", {31'd0, saw_done}, 32'd0);
    prev_q = 8'd0;
    prev_r = 8'd0;
    run_op(8'd50, 8'd6, 0, 8'd0, 8'd0);

    // Randomized operands, with occasional zero and small divisors.
    for (int n = 0; n < 1000; n++) begin
      ra = 8'($urandom_range(0, 255));
      case ($urandom_range(0, 9))
        0:       rb = 8'd0;
        1, 2:    rb = 8'($urandom_range(1, 8));
        default: rb = 8'($urandom_range(1, 255));
      endcase
      run_op(ra, rb, 0, 8'd0, 8'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
